// File: rtl/llm_chi_mst.sv
// llm_chi_mst: single-outstanding CHI request master.
//   Accepts one local request, issues it on the CHI request channel with a
//   version-dependent payload word, waits for the CHI response (or a
//   programmable timeout), then presents the result on the local response port.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   chi_h_version          payload format select (2'b10 = v2.0, else v1.0)
//   timeout_limit          response timeout in cycles, 0 disables
//   lcl_req_*              local request (valid/ready handshake)
//   mst_chi_req_*          CHI request out (valid/ready handshake)
//   mst_chi_resp_*         CHI response in (valid/ready handshake)
//   lcl_rsp_*              local response out (valid/ready handshake)
//   busy, last_latency,
//   err_count, stray_count status
//
// State | meaning
// ------+---------------------------------------------------
// IDLE  | ready for a local request; stray responses dropped
// SEND  | CHI request presented, waiting for slave ready
// WAIT  | waiting for CHI response, timeout timer running
// DELIV | local response presented, waiting for local ready
module llm_chi_mst #(
  parameter int CHI_ADDR_WIDTH = 48,
  parameter int PRIORITY_WIDTH = 3,
  parameter int ADDR_W         = CHI_ADDR_WIDTH,
  parameter int PRI_W          = PRIORITY_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        chi_h_version,
  input  logic [15:0]       timeout_limit,
  input  logic              lcl_req_valid,
  output logic              lcl_req_ready,
  input  logic [ADDR_W-1:0] lcl_req_addr,
  input  logic [511:0]      lcl_req_data,
  input  logic [7:0]        lcl_req_size,
  input  logic [7:0]        lcl_req_type,
  input  logic [1:0]        lcl_req_snp,
  input  logic [PRI_W-1:0]  lcl_req_priority,
  output logic              mst_chi_req_valid,
  input  logic              mst_chi_req_ready,
  output logic [ADDR_W-1:0] mst_chi_req_addr,
  output logic [511:0]      mst_chi_req_data,
  output logic [7:0]        mst_chi_req_size,
  output logic [1:0]        mst_chi_req_snp,
  output logic [63:0]       mst_chi_req_pld,
  output logic [PRI_W-1:0]  mst_chi_req_priority,
  input  logic              mst_chi_resp_valid,
  output logic              mst_chi_resp_ready,
  input  logic [511:0]      mst_chi_resp_data,
  input  logic [1:0]        mst_chi_resp_error,
  input  logic [63:0]       mst_chi_resp_pld,
  input  logic [PRI_W-1:0]  mst_chi_resp_priority,
  output logic              lcl_rsp_valid,
  input  logic              lcl_rsp_ready,
  output logic [511:0]      lcl_rsp_data,
  output logic [1:0]        lcl_rsp_error,
  output logic [63:0]       lcl_rsp_pld,
  output logic              busy,
  output logic [15:0]       last_latency,
  output logic [15:0]       err_count,
  output logic [7:0]        stray_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_REQ = 2'd1,
    WAIT_RSP = 2'd2,
    DELIVER  = 2'd3
  } state_t;

  state_t            state;
  logic [15:0]       wait_cnt;
  logic [63:0]       pld_next;
  logic [PRI_W+2:0]  pri_ext;
  logic              unused_ok;

  // Zero-extend so a narrow priority still fills the 3-bit payload field.
  assign pri_ext = {3'b000, lcl_req_priority};

  assign unused_ok = ^{mst_chi_resp_priority, pri_ext};

  always_comb begin
    pld_next          = '0;
    pld_next[31:24]   = lcl_req_type;
    if (chi_h_version == 2'b10) begin
      pld_next[11:9]  = pri_ext[2:0];
      pld_next[39:32] = lcl_req_size;
    end else begin
      pld_next[7:5]   = pri_ext[2:0];
    end
  end

  assign lcl_req_ready      = (state == IDLE);
  assign mst_chi_resp_ready = (state == IDLE) || (state == WAIT_RSP);
  assign busy               = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      wait_cnt             <= '0;
      mst_chi_req_valid    <= 1'b0;
      mst_chi_req_addr     <= '0;
      mst_chi_req_data     <= '0;
      mst_chi_req_size     <= '0;
      mst_chi_req_snp      <= '0;
      mst_chi_req_pld      <= '0;
      mst_chi_req_priority <= '0;
      lcl_rsp_valid        <= 1'b0;
      lcl_rsp_data         <= '0;
      lcl_rsp_error        <= '0;
      lcl_rsp_pld          <= '0;
      last_latency         <= '0;
      err_count            <= '0;
      stray_count          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mst_chi_resp_valid && (stray_count != 8'hFF))
            stray_count <= stray_count + 8'd1;
          if (lcl_req_valid) begin
            mst_chi_req_addr     <= lcl_req_addr;
            mst_chi_req_data     <= lcl_req_data;
            mst_chi_req_size     <= lcl_req_size;
            mst_chi_req_snp      <= lcl_req_snp;
            mst_chi_req_pld      <= pld_next;
            mst_chi_req_priority <= lcl_req_priority;
            mst_chi_req_valid    <= 1'b1;
            state                <= SEND_REQ;
          end
        end

        SEND_REQ: begin
          if (mst_chi_req_ready) begin
            mst_chi_req_valid <= 1'b0;
            wait_cnt          <= '0;
            state             <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          // Response wins over a coincident timeout.
          if (mst_chi_resp_valid) begin
            lcl_rsp_data  <= mst_chi_resp_data;
            lcl_rsp_error <= mst_chi_resp_error;
            lcl_rsp_pld   <= mst_chi_resp_pld;
            // wait_cnt is 0 in the first WAIT cycle, which is latency 1.
            last_latency  <= (wait_cnt == 16'hFFFF) ? 16'hFFFF : wait_cnt + 16'd1;
            if ((mst_chi_resp_error != 2'b00) && (err_count != 16'hFFFF))
              err_count <= err_count + 16'd1;
            lcl_rsp_valid <= 1'b1;
            state         <= DELIVER;
          end else if ((timeout_limit != 16'd0) && (wait_cnt == timeout_limit)) begin
            lcl_rsp_data  <= '0;
            lcl_rsp_error <= 2'b11;
            lcl_rsp_pld   <= '0;
            if (err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            lcl_rsp_valid <= 1'b1;
            state         <= DELIVER;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        DELIVER: begin
          if (lcl_rsp_ready) begin
            lcl_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_llm_chi_mst.sv
module tb_llm_chi_mst;

  localparam int ADDR_W = 48;
  localparam int PRI_W  = 3;

  logic              clk;
  logic              rst_n;
  logic [1:0]        chi_h_version;
  logic [15:0]       timeout_limit;
  logic              lcl_req_valid;
  logic              lcl_req_ready;
  logic [ADDR_W-1:0] lcl_req_addr;
  logic [511:0]      lcl_req_data;
  logic [7:0]        lcl_req_size;
  logic [7:0]        lcl_req_type;
  logic [1:0]        lcl_req_snp;
  logic [PRI_W-1:0]  lcl_req_priority;
  logic              mst_chi_req_valid;
  logic              mst_chi_req_ready;
  logic [ADDR_W-1:0] mst_chi_req_addr;
  logic [511:0]      mst_chi_req_data;
  logic [7:0]        mst_chi_req_size;
  logic [1:0]        mst_chi_req_snp;
  logic [63:0]       mst_chi_req_pld;
  logic [PRI_W-1:0]  mst_chi_req_priority;
  logic              mst_chi_resp_valid;
  logic              mst_chi_resp_ready;
  logic [511:0]      mst_chi_resp_data;
  logic [1:0]        mst_chi_resp_error;
  logic [63:0]       mst_chi_resp_pld;
  logic [PRI_W-1:0]  mst_chi_resp_priority;
  logic              lcl_rsp_valid;
  logic              lcl_rsp_ready;
  logic [511:0]      lcl_rsp_data;
  logic [1:0]        lcl_rsp_error;
  logic [63:0]       lcl_rsp_pld;
  logic              busy;
  logic [15:0]       last_latency;
  logic [15:0]       err_count;
  logic [7:0]        stray_count;

  llm_chi_mst #(.CHI_ADDR_WIDTH(ADDR_W), .PRIORITY_WIDTH(PRI_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .chi_h_version(chi_h_version), .timeout_limit(timeout_limit),
    .lcl_req_valid(lcl_req_valid), .lcl_req_ready(lcl_req_ready),
    .lcl_req_addr(lcl_req_addr), .lcl_req_data(lcl_req_data),
    .lcl_req_size(lcl_req_size), .lcl_req_type(lcl_req_type),
    .lcl_req_snp(lcl_req_snp), .lcl_req_priority(lcl_req_priority),
    .mst_chi_req_valid(mst_chi_req_valid), .mst_chi_req_ready(mst_chi_req_ready),
    .mst_chi_req_addr(mst_chi_req_addr), .mst_chi_req_data(mst_chi_req_data),
    .mst_chi_req_size(mst_chi_req_size), .mst_chi_req_snp(mst_chi_req_snp),
    .mst_chi_req_pld(mst_chi_req_pld), .mst_chi_req_priority(mst_chi_req_priority),
    .mst_chi_resp_valid(mst_chi_resp_valid), .mst_chi_resp_ready(mst_chi_resp_ready),
    .mst_chi_resp_data(mst_chi_resp_data), .mst_chi_resp_error(mst_chi_resp_error),
    .mst_chi_resp_pld(mst_chi_resp_pld), .mst_chi_resp_priority(mst_chi_resp_priority),
    .lcl_rsp_valid(lcl_rsp_valid), .lcl_rsp_ready(lcl_rsp_ready),
    .lcl_rsp_data(lcl_rsp_data), .lcl_rsp_error(lcl_rsp_error),
    .lcl_rsp_pld(lcl_rsp_pld), .busy(busy), .last_latency(last_latency),
    .err_count(err_count), .stray_count(stray_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ver;
    logic [7:0]  typ;
    logic [7:0]  size;
    logic [2:0]  pri;
    logic [1:0]  err;
    logic [63:0] exp_pld;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] ver, input logic [7:0] typ,
                       input logic [7:0] size, input logic [2:0] pri,
                       input logic [ADDR_W-1:0] addr);
    chi_h_version    = ver;
    lcl_req_type     = typ;
    lcl_req_size     = size;
    lcl_req_priority = pri;
    lcl_req_addr     = addr;
    lcl_req_data     = {16{32'hA5A5_0000 | 32'(typ)}};
    lcl_req_snp      = 2'b01;
    lcl_req_valid    = 1'b1;
    chk("lcl_req_ready_idle", {63'b0, lcl_req_ready}, 64'd1);
    tick();
    lcl_req_valid    = 1'b0;
  endtask

  logic [511:0] rdata;
  logic [63:0]  hold_pld;
  logic [511:0] hold_data;
  int n;

  initial begin
    vecs[0] = '{2'b01, 8'h05, 8'h10, 3'b101, 2'b00, 64'h0000_0000_0500_00A0};
    vecs[1] = '{2'b10, 8'h04, 8'h40, 3'b011, 2'b00, 64'h0000_0040_0400_0600};
    vecs[2] = '{2'b00, 8'h01, 8'hFF, 3'b111, 2'b10, 64'h0000_0000_0100_00E0};
    vecs[3] = '{2'b11, 8'h06, 8'h80, 3'b001, 2'b00, 64'h0000_0000_0600_0020};
    vecs[4] = '{2'b10, 8'h02, 8'hFF, 3'b111, 2'b01, 64'h0000_00FF_0200_0E00};
    vecs[5] = '{2'b10, 8'h03, 8'h01, 3'b000, 2'b11, 64'h0000_0001_0300_0000};

    rst_n = 1'b0;
    chi_h_version = 2'b01; timeout_limit = 16'd0;
    lcl_req_valid = 1'b0; lcl_req_addr = '0; lcl_req_data = '0; lcl_req_size = '0;
    lcl_req_type = '0; lcl_req_snp = '0; lcl_req_priority = '0;
    mst_chi_req_ready = 1'b0; mst_chi_resp_valid = 1'b0; mst_chi_resp_data = '0;
    mst_chi_resp_error = '0; mst_chi_resp_pld = '0; mst_chi_resp_priority = '0;
    lcl_rsp_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_req_valid", {63'b0, mst_chi_req_valid}, 64'd0);
    chk("rst_rsp_valid", {63'b0, lcl_rsp_valid}, 64'd0);
    chk("rst_lcl_req_ready", {63'b0, lcl_req_ready}, 64'd1);
    chk("rst_resp_ready", {63'b0, mst_chi_resp_ready}, 64'd1);
    chk("rst_pld", mst_chi_req_pld, 64'd0);
    chk("rst_counters", {last_latency, err_count, 8'd0, stray_count}, 64'd0);
    rst_n = 1'b1;

    // Timeout with no response, then a stray response in IDLE
    timeout_limit = 16'd10;
    issue(2'b01, 8'h05, 8'h08, 3'b010, 48'h0000_0000_1000);
    mst_chi_req_ready = 1'b1;
    tick();
    mst_chi_req_ready = 1'b0;
    n = 0;
    while (!lcl_rsp_valid && n < 50) begin tick(); n++; end
    chk("to_cycles", 64'(n), 64'd11);
    chk("to_error", {62'b0, lcl_rsp_error}, 64'd3);
    chk("to_data_zero", {63'b0, lcl_rsp_data == '0}, 64'd1);
    chk("to_pld_zero", lcl_rsp_pld, 64'd0);
    chk("to_err_count", {48'b0, err_count}, 64'd1);
    chk("to_latency_kept", {48'b0, last_latency}, 64'd0);
    lcl_rsp_ready = 1'b1;
    tick();
    lcl_rsp_ready = 1'b0;
    chk("to_idle", {63'b0, busy}, 64'd0);
    mst_chi_resp_valid = 1'b1;
    mst_chi_resp_data  = {16{32'hDEAD_BEEF}};
    tick();
    mst_chi_resp_valid = 1'b0;
    chk("stray_count", {56'b0, stray_count}, 64'd1);
    chk("stray_no_rsp", {62'b0, lcl_rsp_valid, busy}, 64'd0);

    // Reset asserted while waiting for a response
    issue(2'b01, 8'h02, 8'h04, 3'b001, 48'h0000_0000_2000);
    mst_chi_req_ready = 1'b1;
    tick();
    mst_chi_req_ready = 1'b0;
    chk("mid_in_wait", {62'b0, busy, mst_chi_resp_ready}, 64'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", {63'b0, busy}, 64'd0);
    chk("mid_counters", {last_latency, err_count, 8'd0, stray_count}, 64'd0);
    chk("mid_rsp_valid", {63'b0, lcl_rsp_valid}, 64'd0);
    tick(); tick();
    chk("mid_rsp_valid_later", {62'b0, lcl_rsp_valid, busy}, 64'd0);

    // Table: minimum-latency transactions across payload formats
    timeout_limit = 16'd100;
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].ver, vecs[i].typ, vecs[i].size, vecs[i].pri, 48'h0000_0000_3000 + 48'(i));
      chk($sformatf("v%0d_req_valid", i), {63'b0, mst_chi_req_valid}, 64'd1);
      chk($sformatf("v%0d_pld", i), mst_chi_req_pld, vecs[i].exp_pld);
      chk($sformatf("v%0d_size", i), {56'b0, mst_chi_req_size}, {56'b0, vecs[i].size});
      chk($sformatf("v%0d_addr", i), {16'b0, mst_chi_req_addr}, 64'h3000 + 64'(i));
      mst_chi_req_ready = 1'b1;
      tick();
      mst_chi_req_ready = 1'b0;
      chk($sformatf("v%0d_wait", i), {62'b0, mst_chi_req_valid, mst_chi_resp_ready}, 64'd1);
      rdata = {16{32'h1234_0000 + 32'(i)}};
      mst_chi_resp_valid = 1'b1;
      mst_chi_resp_data  = rdata;
      mst_chi_resp_error = vecs[i].err;
      mst_chi_resp_pld   = 64'hC0DE_0000_0000_0000 + 64'(i);
      tick();
      mst_chi_resp_valid = 1'b0;
      if (vecs[i].err != 2'b00) exp_err++;
      chk($sformatf("v%0d_rsp_valid", i), {63'b0, lcl_rsp_valid}, 64'd1);
      chk($sformatf("v%0d_rsp_data", i), {63'b0, lcl_rsp_data == rdata}, 64'd1);
      chk($sformatf("v%0d_rsp_error", i), {62'b0, lcl_rsp_error}, {62'b0, vecs[i].err});
      chk($sformatf("v%0d_rsp_pld", i), lcl_rsp_pld, 64'hC0DE_0000_0000_0000 + 64'(i));
      chk($sformatf("v%0d_latency", i), {48'b0, last_latency}, 64'd1);
      chk($sformatf("v%0d_err_count", i), {48'b0, err_count}, 64'(exp_err));
      lcl_rsp_ready = 1'b1;
      tick();
      lcl_rsp_ready = 1'b0;
      chk($sformatf("v%0d_done", i), {62'b0, lcl_rsp_valid, busy}, 64'd0);
    end

    // v2.0 request held under 5 cycles of slave backpressure
    issue(2'b10, 8'h04, 8'h40, 3'b011, 48'h0000_0000_4000);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("bp_valid_%0d", c), {63'b0, mst_chi_req_valid}, 64'd1);
      chk($sformatf("bp_pld_%0d", c), mst_chi_req_pld, 64'h0000_0040_0400_0600);
      chk($sformatf("bp_addr_%0d", c), {16'b0, mst_chi_req_addr}, 64'h4000);
      if (c == 5) mst_chi_req_ready = 1'b1;
      tick();
    end
    mst_chi_req_ready = 1'b0;
    chk("bp_released", {63'b0, mst_chi_req_valid}, 64'd0);
    tick(); tick();
    mst_chi_resp_valid = 1'b1;
    mst_chi_resp_data  = {16{32'h5555_AAAA}};
    mst_chi_resp_error = 2'b00;
    tick();
    mst_chi_resp_valid = 1'b0;
    chk("bp_latency", {48'b0, last_latency}, 64'd3);
    lcl_rsp_ready = 1'b1;
    tick();
    lcl_rsp_ready = 1'b0;

    // Response arriving in the timeout cycle wins
    timeout_limit = 16'd10;
    issue(2'b01, 8'h05, 8'h01, 3'b100, 48'h0000_0000_5000);
    mst_chi_req_ready = 1'b1;
    tick();
    mst_chi_req_ready = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("tie_not_yet", {63'b0, lcl_rsp_valid}, 64'd0);
    rdata = {16{32'h7777_1111}};
    mst_chi_resp_valid = 1'b1;
    mst_chi_resp_data  = rdata;
    mst_chi_resp_error = 2'b00;
    mst_chi_resp_pld   = 64'h1111_2222_3333_4444;
    tick();
    mst_chi_resp_valid = 1'b0;
    chk("tie_error", {62'b0, lcl_rsp_error}, 64'd0);
    chk("tie_data", {63'b0, lcl_rsp_data == rdata}, 64'd1);
    chk("tie_pld", lcl_rsp_pld, 64'h1111_2222_3333_4444);
    chk("tie_latency", {48'b0, last_latency}, 64'd11);
    chk("tie_err_count", {48'b0, err_count}, 64'(exp_err));
    lcl_rsp_ready = 1'b1;
    tick();
    lcl_rsp_ready = 1'b0;

    // ECC error response held while the local side stalls
    issue(2'b01, 8'h03, 8'h02, 3'b110, 48'h0000_0000_6000);
    mst_chi_req_ready = 1'b1;
    tick();
    mst_chi_req_ready = 1'b0;
    rdata = {16{32'hECC0_0001}};
    mst_chi_resp_valid = 1'b1;
    mst_chi_resp_data  = rdata;
    mst_chi_resp_error = 2'b01;
    mst_chi_resp_pld   = 64'h0000_0000_0000_00EC;
    tick();
    mst_chi_resp_valid = 1'b0;
    mst_chi_resp_data  = '0;
    mst_chi_resp_error = 2'b00;
    mst_chi_resp_pld   = '0;
    exp_err++;
    hold_pld  = 64'h0000_0000_0000_00EC;
    hold_data = rdata;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ecc_valid_%0d", c), {63'b0, lcl_rsp_valid}, 64'd1);
      chk($sformatf("ecc_error_%0d", c), {62'b0, lcl_rsp_error}, 64'd1);
      chk($sformatf("ecc_data_%0d", c), {63'b0, lcl_rsp_data == hold_data}, 64'd1);
      chk($sformatf("ecc_pld_%0d", c), lcl_rsp_pld, hold_pld);
      chk($sformatf("ecc_err_count_%0d", c), {48'b0, err_count}, 64'(exp_err));
      if (c == 3) lcl_rsp_ready = 1'b1;
      tick();
    end
    lcl_rsp_ready = 1'b0;
    chk("ecc_done", {62'b0, lcl_rsp_valid, busy}, 64'd0);
    chk("ecc_err_count_final", {48'b0, err_count}, 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llm_chi_mst.md
LLM_CHI_MST -- requirements
Module: llm_chi_mst

Interface
REQ-001 SHALL provide parameter ADDR_W, default CHI_ADDR_WIDTH, request address width.
REQ-002 SHALL provide parameter PRI_W, default PRIORITY_WIDTH, priority width.
REQ-003 SHALL use one clock and a synchronous, active-low reset: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have the following configuration ports: chi_h_version  in  2  pld format (01 v1.0, 10 v2.0, 00/11 treated as v1.0); timeout_limit  in  16  response timeout in cycles, 0 disables.
REQ-005 SHALL have the following local request ports: lcl_req_valid  in  1; lcl_req_ready  out  1; lcl_req_addr  in  ADDR_W; lcl_req_data  in  512; lcl_req_size  in  8; lcl_req_type  in  8  CHI type code 01..06; lcl_req_snp  in  2; lcl_req_priority  in  PRI_W.
REQ-006 SHALL have the following CHI request ports: mst_chi_req_valid  out  1; mst_chi_req_ready  in  1; mst_chi_req_addr  out  ADDR_W; mst_chi_req_data  out  512; mst_chi_req_size  out  8; mst_chi_req_snp  out  2; mst_chi_req_pld  out  64; mst_chi_req_priority  out  PRI_W.
REQ-007 SHALL have the following CHI response ports: mst_chi_resp_valid  in  1; mst_chi_resp_ready  out  1; mst_chi_resp_data  in  512; mst_chi_resp_error  in  2  (00 ok, 01 ECC, 10 protocol, 11 timeout); mst_chi_resp_pld  in  64; mst_chi_resp_priority  in  PRI_W.
REQ-008 SHALL have the following local response ports: lcl_rsp_valid  out  1; lcl_rsp_ready  in  1; lcl_rsp_data  out  512; lcl_rsp_error  out  2; lcl_rsp_pld  out  64.
REQ-009 SHALL have the following status ports: busy  out  1  state != IDLE; last_latency  out  16  cycles from CHI request handshake to response handshake; err_count  out  16  errored responses delivered; stray_count  out  8  responses discarded in IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> SEND_REQ -> WAIT_RSP -> DELIVER -> IDLE, one transaction outstanding.
REQ-011 SHALL drive lcl_req_ready=1 combinationally only in IDLE; handshake lcl_req_valid&lcl_req_ready registers all request fields and moves to SEND_REQ.
REQ-012 SHALL build pld: [31:24]=lcl_req_type; v1.0 priority at [7:5]; v2.0 priority at [11:9] and [39:32]=lcl_req_size; all other bits 0.
REQ-013 SHALL assert mst_chi_req_valid throughout SEND_REQ with all request outputs stable until mst_chi_req_ready; the handshake moves to WAIT_RSP.
REQ-014 SHALL assert mst_chi_resp_ready in WAIT_RSP and IDLE only.
REQ-015 SHALL, on a response handshake in WAIT_RSP, capture data/error/pld into the lcl_rsp_* registers and move to DELIVER.
REQ-016 SHALL hold lcl_rsp_valid=1 with stable outputs throughout DELIVER; lcl_rsp_ready moves to IDLE.
REQ-017 SHALL count WAIT_RSP cycles in a 16-bit timer cleared on entry; if timer==timeout_limit (nonzero) with no response, go to DELIVER with lcl_rsp_error=11, data and pld 0.
REQ-018 SHALL give the response priority when a response and the timeout occur in the same cycle.
REQ-019 SHALL, when any response arrives in IDLE, accept and discard it and increment stray_count (saturating at 8'hFF).
REQ-020 SHALL count latency from the cycle after the request handshake, saturating at 16'hFFFF, and load last_latency on the response handshake; a timeout leaves last_latency unchanged.
REQ-021 SHALL increment err_count (saturating at 16'hFFFF) once per DELIVER entry with lcl_rsp_error!=00.
REQ-022 SHALL give minimum latency: local accept at cycle 0; mst_chi_req_valid at cycle 1; response accepted at cycle 2; lcl_rsp_valid at cycle 3.

Reset
REQ-023 SHALL, while rst_n=0 at a clk edge, force state IDLE and all outputs, counters and registered fields to 0; lcl_req_ready and mst_chi_resp_ready then read 1 per IDLE.
REQ-024 SHALL, on reset mid-transaction, abandon the transaction with no local response.

Verification
REQ-025 SHALL verify v1.0 read: type 05, priority 3'b101 -> pld 64'h0000_0000_0500_00A0; slave ready and response at cycle 2 with error 00 -> lcl_rsp_valid at cycle 3, last_latency=1.
REQ-026 SHALL verify v2.0 backpressure: type 04, priority 3'b011, size 8'h40, slave ready low 5 cycles -> pld 64'h0000_0040_0400_0600 held stable for 6 cycles.
REQ-027 SHALL verify timeout: timeout_limit=10 with no response -> DELIVER with error 11 and err_count=1; a later response in IDLE sets stray_count=1.
REQ-028 SHALL verify response and timeout in the same cycle -> slave data delivered with error 00.
REQ-029 SHALL verify reset asserted in WAIT_RSP -> next cycle busy=0, all counters 0, no lcl_rsp_valid.
REQ-030 SHALL verify error 01 response with lcl_rsp_ready low 3 cycles -> lcl_rsp_* held stable and err_count incremented exactly once.
